wb_select_stage: RTL and testbench

//  Parametrised writeback source selector with a 2-entry output buffer, placed between the execute/memory stages and the register-file write port.

---
 rtl/wb_pkg.sv | 28 ++
 rtl/wb_skid_fifo2.sv | 71 +++++++
 rtl/wb_select_stage.sv | 121 ++++++++++++
 tb/tb_wb_select_stage.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Package: wb_pkg
// Shared types, constants and select-decode helpers for the writeback
// select stage (wb_select_stage) and its output FIFO (wb_skid_fifo2).
//   ld_size_e        : load size encoding for the load extension
//   WB_CONST_DEFAULT : default constant driven when sel == NUM_SRC
//   WB_FIFO_DEPTH    : depth of the writeback output buffer
//   sel_is_const     : sel selects the fixed constant
//   sel_is_bad       : sel is outside the legal range (> NUM_SRC)
package wb_pkg;

   typedef enum logic [1:0] {
      LD_BYTE = 2'd0,
      LD_HALF = 2'd1,
      LD_WORD = 2'd2
   } ld_size_e;

   localparam int WB_CONST_DEFAULT = 227;
   localparam int WB_FIFO_DEPTH    = 2;

   function automatic logic sel_is_const(input int sel, input int num_src);
      return (sel == num_src);
   endfunction

   function automatic logic sel_is_bad(input int sel, input int num_src);
      return (sel > num_src);
   endfunction

endpackage

// File: rtl/wb_skid_fifo2.sv
// Module: wb_skid_fifo2
// Two-entry FIFO holding {dest_addr, data} writeback results. The head
// entry is read straight out of registered storage, so an entry becomes
// visible on rd_* one cycle after the edge that wrote it.
// Ports:
//   clk, rst   : clock (rising edge), asynchronous active-high reset
//   flush      : synchronous discard of all entries and any same-cycle write
//   wr_valid/wr_ready/wr_data : write side
//   rd_valid/rd_ready/rd_data : read side (head entry)
// Handshake: a transfer happens on a rising edge where valid & ready are
// both high; valid never waits on ready, and data is stable while
// valid & ~ready.
module wb_skid_fifo2
   import wb_pkg::*;
#(
   parameter int W = 37
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         wr_valid,
   output logic         wr_ready,
   input  logic [W-1:0] wr_data,
   output logic         rd_valid,
   input  logic         rd_ready,
   output logic [W-1:0] rd_data
);

   logic [W-1:0] mem [WB_FIFO_DEPTH];
   logic         head;
   logic         tail;
   logic [1:0]   count;
   logic         push;
   logic         pop;

   // Not ready during reset so nothing upstream believes a result was taken.
   assign wr_ready = (count != 2'd2) & ~rst;
   assign rd_valid = (count != 2'd0);
   assign rd_data  = mem[head];
   assign push     = wr_valid & wr_ready;
   assign pop      = rd_valid & rd_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // Storage is cleared so the head reads as zero out of reset.
         mem[0] <= '0;
         mem[1] <= '0;
         head   <= 1'b0;
         tail   <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         head  <= 1'b0;
         tail  <= 1'b0;
         count <= 2'd0;
      end else begin
         if (push) begin
            mem[tail] <= wr_data;
            tail      <= ~tail;
         end
         if (pop) begin
            head <= ~head;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/wb_select_stage.sv
// Module: wb_select_stage
// Writeback source selector with a 2-entry output buffer between the
// execute/memory stages and the register-file write port. Picks one of
// NUM_SRC sources (or CONST_VAL when sel == NUM_SRC, or 0 for an
// out-of-range sel), tags it with dest_addr and queues it.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   flush                 : discard buffered and same-cycle incoming results
//   in_valid / in_ready   : upstream handshake
//   sel, src, dest_addr   : source select, flattened sources, destination
//   wb_valid / wb_ready   : register-file handshake (head entry)
//   wb_addr, wb_data      : head destination and data
//   bad_sel               : sticky, set when an accepted sel was > NUM_SRC
// Optional feature macro: LOAD_EXT_EN adds ld_size, ld_signed, ld_off and
// applies byte/half/word extraction with sign/zero extension to the
// MEM_IDX source before it is queued. Without it MEM_IDX passes unchanged.
// Handshake: push on in_valid & in_ready, pop on wb_valid & wb_ready, both
// at the rising edge; results reach wb_* one cycle after acceptance.
module wb_select_stage
   import wb_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int NUM_SRC   = 5,
   parameter int SEL_W     = 3,
   parameter int ADDR_W    = 5,
   parameter int CONST_VAL = WB_CONST_DEFAULT,
   parameter int MEM_IDX   = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [SEL_W-1:0]          sel,
   input  logic [NUM_SRC*DATA_W-1:0] src,
   input  logic [ADDR_W-1:0]         dest_addr,
`ifdef LOAD_EXT_EN
   input  logic [1:0]                ld_size,
   input  logic                      ld_signed,
   input  logic [1:0]                ld_off,
`endif
   output logic                      wb_valid,
   input  logic                      wb_ready,
   output logic [ADDR_W-1:0]         wb_addr,
   output logic [DATA_W-1:0]         wb_data,
   output logic                      bad_sel
);

   // Reject configurations where the constant slot cannot be encoded or
   // the memory source index does not exist.
   if ((2 ** SEL_W) <= NUM_SRC) begin : g_bad_sel_w
      $error("SEL_W too narrow for NUM_SRC");
   end
   if (MEM_IDX >= NUM_SRC) begin : g_bad_mem_idx
      $error("MEM_IDX out of range");
   end

   logic [DATA_W-1:0]        raw;
   logic [DATA_W-1:0]        sel_data;
   logic [ADDR_W+DATA_W-1:0] head;
   logic                     push;

   // Source mux; out-of-range selects fall through to zero.
   always_comb begin
      raw = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (sel == SEL_W'(i)) raw = src[i*DATA_W +: DATA_W];
      end
      if (sel_is_const(int'(sel), NUM_SRC)) raw = DATA_W'(CONST_VAL);
   end

`ifdef LOAD_EXT_EN
   logic [4:0]        shamt;
   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] ext;

   // Halfwords are always halfword aligned, so only ld_off[1] matters.
   always_comb begin
      shamt    = (ld_size_e'(ld_size) == LD_HALF) ? {ld_off[1], 4'b0000}
                                                  : {ld_off, 3'b000};
      shifted  = raw >> shamt;
      case (ld_size_e'(ld_size))
         LD_BYTE: ext = {{(DATA_W-8){ld_signed & shifted[7]}}, shifted[7:0]};
         LD_HALF: ext = {{(DATA_W-16){ld_signed & shifted[15]}}, shifted[15:0]};
         default: ext = raw;
      endcase
      sel_data = (sel == SEL_W'(MEM_IDX)) ? ext : raw;
   end
`else
   assign sel_data = raw;
`endif

   assign push = in_valid & in_ready;

   // bad_sel survives flush; only reset clears it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bad_sel <= 1'b0;
      end else if (push && sel_is_bad(int'(sel), NUM_SRC)) begin
         bad_sel <= 1'b1;
      end
   end

   wb_skid_fifo2 #(
      .W(ADDR_W + DATA_W)
   ) u_fifo (
      .clk      (clk),
      .rst      (reset),
      .flush    (flush),
      .wr_valid (in_valid),
      .wr_ready (in_ready),
      .wr_data  ({dest_addr, sel_data}),
      .rd_valid (wb_valid),
      .rd_ready (wb_ready),
      .rd_data  (head)
   );

   assign wb_addr = head[ADDR_W+DATA_W-1:DATA_W];
   assign wb_data = head[DATA_W-1:0];

endmodule

// File: tb/tb_wb_select_stage.sv
// Testbench for wb_select_stage: directed vectors with hand-computed
// expected results, a driver pushing expectations into exp_q, and a
// monitor popping and comparing on every accepted writeback.
module tb_wb_select_stage;

   localparam int DATA_W  = 32;
   localparam int NUM_SRC = 5;
   localparam int SEL_W   = 3;
   localparam int ADDR_W  = 5;
   localparam int W       = ADDR_W + DATA_W;

   logic                      clk = 1'b0;
   logic                      reset;
   logic                      flush;
   logic                      in_valid;
   logic                      in_ready;
   logic [SEL_W-1:0]          sel;
   logic [NUM_SRC*DATA_W-1:0] src;
   logic [ADDR_W-1:0]         dest_addr;
`ifdef LOAD_EXT_EN
   logic [1:0]                ld_size;
   logic                      ld_signed;
   logic [1:0]                ld_off;
`endif
   logic                      wb_valid;
   logic                      wb_ready;
   logic [ADDR_W-1:0]         wb_addr;
   logic [DATA_W-1:0]         wb_data;
   logic                      bad_sel;

   logic [W-1:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   wb_select_stage dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sel       (sel),
      .src       (src),
      .dest_addr (dest_addr),
`ifdef LOAD_EXT_EN
      .ld_size   (ld_size),
      .ld_signed (ld_signed),
      .ld_off    (ld_off),
`endif
      .wb_valid  (wb_valid),
      .wb_ready  (wb_ready),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .bad_sel   (bad_sel)
   );

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [SEL_W-1:0] s, input logic [DATA_W-1:0] v,
                       input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] e);
      int t;
      for (int i = 0; i < NUM_SRC; i++) src[i*DATA_W +: DATA_W] = 32'hA000_0000 | i;
      if (int'(s) < NUM_SRC) src[int'(s)*DATA_W +: DATA_W] = v;
      sel       = s;
      dest_addr = d;
      in_valid  = 1'b1;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 50) begin
         t++;
         @(negedge clk);
      end
      if (!in_ready) begin
         check("send_accept_timeout", 64'(in_ready), 64'd1);
      end else begin
         exp_q.push_back({d, e});
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 50) begin
         t++;
         @(posedge clk);
         #1;
      end
      if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   // ---------------- scoreboard monitor ----------------
   initial begin
      logic [W-1:0] exp;
      forever begin
         @(negedge clk);
         if (!reset && wb_valid && wb_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_wb: got addr %0h data %0h expected none",
                        wb_addr, wb_data);
            end else begin
               exp = exp_q.pop_front();
               check("wb_out", 64'({wb_addr, wb_data}), 64'(exp));
            end
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      sel       = '0;
      src       = '0;
      dest_addr = '0;
      wb_ready  = 1'b0;
`ifdef LOAD_EXT_EN
      ld_size   = 2'd2;
      ld_signed = 1'b0;
      ld_off    = 2'd0;
`endif
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_wb_valid", 64'(wb_valid), 64'd0);
      check("rst_wb_addr",  64'(wb_addr),  64'd0);
      check("rst_wb_data",  64'(wb_data),  64'd0);
      check("rst_bad_sel",  64'(bad_sel),  64'd0);
      reset = 1'b0;
      #1;
      check("post_rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;

      // Basic select with latency 1
      wb_ready = 1'b1;
      send(3'd0, 32'h0000_1234, 5'd9, 32'h0000_1234);
      check("lat1_valid", 64'(wb_valid), 64'd1);
      check("lat1_addr",  64'(wb_addr),  64'd9);
      check("lat1_data",  64'(wb_data),  64'h1234);
      send(3'd2, 32'hCAFE_F00D, 5'd17, 32'hCAFE_F00D);
      send(3'd4, 32'h1357_9BDF, 5'd31, 32'h1357_9BDF);
      send(3'd1, 32'h8000_0001, 5'd0,  32'h8000_0001);
      wait_drain();

      // Constant and illegal selects; bad_sel survives flush
      send(3'd5, 32'h0, 5'd1, 32'd227);
      check("bad_sel_after_const", 64'(bad_sel), 64'd0);
      send(3'd7, 32'h0, 5'd2, 32'd0);
      check("bad_sel_set", 64'(bad_sel), 64'd1);
      wait_drain();
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("bad_sel_after_flush", 64'(bad_sel), 64'd1);

      // Backpressure: 3 pushes with wb_ready low
      wb_ready = 1'b0;
      fork
         begin
            send(3'd0, 32'h111, 5'd1, 32'h111);
            send(3'd0, 32'h222, 5'd2, 32'h222);
            send(3'd0, 32'h333, 5'd3, 32'h333);
         end
         begin
            repeat (4) @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_wb_valid", 64'(wb_valid), 64'd1);
            check("bp_hold_data", 64'(wb_data), 64'h111);
            @(posedge clk);
            #1;
            check("bp_hold_data2", 64'(wb_data), 64'h111);
            wb_ready = 1'b1;
         end
      join
      wait_drain();

      // count=1 with simultaneous push/pop across pointer wrap
      wb_ready = 1'b0;
      send(3'd3, 32'hA1, 5'd10, 32'hA1);
      wb_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         send(3'd3, 32'hB0 + k, 5'(11 + k), 32'hB0 + k);
         check("pp_wb_valid", 64'(wb_valid), 64'd1);
         check("pp_in_ready", 64'(in_ready), 64'd1);
      end
      wait_drain();

      // Flush with count=2 and incoming data
      wb_ready = 1'b0;
      send(3'd0, 32'h444, 5'd4, 32'h444);
      send(3'd0, 32'h445, 5'd5, 32'h445);
      src[DATA_W-1:0] = 32'hBAD;
      sel       = 3'd0;
      dest_addr = 5'd3;
      in_valid  = 1'b1;
      flush     = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush2_wb_valid", 64'(wb_valid), 64'd0);
      check("flush2_in_ready", 64'(in_ready), 64'd1);
      // Flush with count=1 while a push is accepted in the same cycle
      send(3'd0, 32'h446, 5'd6, 32'h446);
      in_valid = 1'b1;
      flush    = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush1_wb_valid", 64'(wb_valid), 64'd0);
      wb_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // Asynchronous reset in the middle of a drain
      wb_ready = 1'b0;
      send(3'd0, 32'h555, 5'd5, 32'h555);
      send(3'd0, 32'h666, 5'd6, 32'h666);
      wb_ready = 1'b1;
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("areset_wb_valid", 64'(wb_valid), 64'd0);
      check("areset_in_ready", 64'(in_ready), 64'd0);
      exp_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("areset_wb_data", 64'(wb_data), 64'd0);
      check("areset_bad_sel", 64'(bad_sel), 64'd0);
      repeat (4) @(posedge clk);
      #1;

`ifdef LOAD_EXT_EN
      ld_size   = 2'd0;
      ld_signed = 1'b1;
      ld_off    = 2'd2;
      send(3'd1, 32'h80FF_7F01, 5'd4, 32'hFFFF_FFFF);
      ld_size   = 2'd1;
      ld_signed = 1'b0;
      ld_off    = 2'd2;
      send(3'd1, 32'h80FF_7F01, 5'd5, 32'h0000_80FF);
      ld_size   = 2'd2;
      ld_off    = 2'd0;
      wait_drain();
`endif

      wait_drain();
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
